// File: rtl/ds1302_pkg.sv
// ds1302_pkg: state encoding, 56-bit time-vector layout and BCD limits shared by the DS1302 scheduler.
package ds1302_pkg;
  typedef enum logic [1:0] {S_WRITE, S_READ, S_POLL} state_t;
  localparam int FIELD_W = 8;
  localparam int TIME_W = 56;
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 8;
  localparam int HOUR_LSB = 16;
  localparam int DATE_LSB = 24;
  localparam int MONTH_LSB = 32;
  localparam int WEEK_LSB = 40;
  localparam int YEAR_LSB = 48;
  localparam int CH_BIT = 7;
  localparam int HOUR_12H_BIT = 7;
  localparam logic [7:0] CH_MASK = 8'(1) << CH_BIT;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] DATE_MIN = 8'h01;
  localparam logic [7:0] DATE_MAX = 8'h31;
  localparam logic [7:0] MONTH_MIN = 8'h01;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] WEEK_MIN = 8'h01;
  localparam logic [7:0] WEEK_MAX = 8'h07;
  localparam logic [7:0] YEAR_MAX = 8'h99;
  function automatic logic bcd_ok(input logic [7:0] v);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction
  // Clock-halt off and 24 h mode: the only encodings this scheduler ever writes.
  function automatic logic [TIME_W-1:0] mask_time(input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] m;
    m = t;
    m[SEC_LSB + CH_BIT] = 1'b0;
    m[HOUR_LSB + HOUR_12H_BIT] = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/ds1302_time_check.sv
// ds1302_time_check: combinational BCD/range validity check of a {year,week,month,date,hour,minute,second} vector.
module ds1302_time_check
  import ds1302_pkg::*;
(
  input  logic [TIME_W-1:0] tm,
  output logic              valid
);
  logic [7:0] sec, min, hour, date, month, week, year;
  assign sec = tm[SEC_LSB +: FIELD_W];
  assign min = tm[MIN_LSB +: FIELD_W];
  assign hour = tm[HOUR_LSB +: FIELD_W];
  assign date = tm[DATE_LSB +: FIELD_W];
  assign month = tm[MONTH_LSB +: FIELD_W];
  assign week = tm[WEEK_LSB +: FIELD_W];
  assign year = tm[YEAR_LSB +: FIELD_W];
  assign valid = bcd_ok(sec) && sec <= SEC_MAX
              && bcd_ok(min) && min <= MIN_MAX
              && bcd_ok(hour) && hour <= HOUR_MAX
              && bcd_ok(date) && date >= DATE_MIN && date <= DATE_MAX
              && bcd_ok(month) && month >= MONTH_MIN && month <= MONTH_MAX
              && bcd_ok(week) && week >= WEEK_MIN && week <= WEEK_MAX
              && bcd_ok(year) && year <= YEAR_MAX;
endmodule

// File: rtl/ds1302_time_sched.sv
// ds1302_time_sched: init-write, periodic calendar poll and user set-time scheduling in front of the DS1302 controller.
module ds1302_time_sched
  import ds1302_pkg::*;
#(
  parameter int          POLL_CYCLES   = 100_000,
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter logic [55:0] INIT_TIME     = 56'h24_01_01_01_00_00_00
) (
  input  logic        ds1302_clk,
  input  logic        ds1302_rst,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic        set_err,
  output logic [7:0]  write_second,
  output logic [7:0]  write_minute,
  output logic [7:0]  write_hour,
  output logic [7:0]  write_date,
  output logic [7:0]  write_month,
  output logic [7:0]  write_week,
  output logic [7:0]  write_year,
  output logic        write_time_req,
  input  logic        write_time_ack,
  input  logic [7:0]  read_second,
  input  logic [7:0]  read_minute,
  input  logic [7:0]  read_hour,
  input  logic [7:0]  read_date,
  input  logic [7:0]  read_month,
  input  logic [7:0]  read_week,
  input  logic [7:0]  read_year,
  output logic        read_time_req,
  input  logic        read_time_ack,
  output logic [7:0]  time_second,
  output logic [7:0]  time_minute,
  output logic [7:0]  time_hour,
  output logic [7:0]  time_date,
  output logic [7:0]  time_month,
  output logic [7:0]  time_week,
  output logic [7:0]  time_year,
  output logic        time_valid,
  output logic        sec_tick
);
  localparam int TW = POLL_CYCLES > 1 ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0] TERM = TW'(POLL_CYCLES - 1);
  localparam state_t RST_STATE = INIT_ON_RESET ? S_WRITE : S_READ;
  state_t state;
  logic [TW-1:0] timer;
  logic pend_set, set_ok, accept;
  logic [TIME_W-1:0] pend_time, wr_time, tm;
  logic [7:0] rd_sec;
  ds1302_time_check u_check (.tm(set_time), .valid(set_ok));
  assign accept = set_req && set_ok && state != S_WRITE;
  assign rd_sec = read_second & ~CH_MASK;
  assign {write_year, write_week, write_month, write_date, write_hour, write_minute, write_second} = wr_time;
  assign {time_year, time_week, time_month, time_date, time_hour, time_minute, time_second} = tm;
  // Each req is cleared on the edge that samples its ack so the controller sees it low when back in IDLE.
  always_ff @(posedge ds1302_clk or negedge ds1302_rst) begin
    if (!ds1302_rst) begin
      state <= RST_STATE;
      timer <= '0;
      pend_set <= 1'b0;
      pend_time <= '0;
      wr_time <= mask_time(INIT_TIME);
      tm <= '0;
      time_valid <= 1'b0;
      sec_tick <= 1'b0;
      set_err <= 1'b0;
      write_time_req <= 1'b0;
      read_time_req <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      set_err <= set_req && !accept;
      timer <= '0;
      case (state)
        S_WRITE:
          if (write_time_req && write_time_ack) begin
            write_time_req <= 1'b0;
            read_time_req <= 1'b1;
            state <= S_READ;
          end else write_time_req <= 1'b1;
        S_READ:
          if (read_time_req && read_time_ack) begin
            read_time_req <= 1'b0;
            state <= S_POLL;
            tm <= {read_year, read_week, read_month, read_date, read_hour, read_minute, rd_sec};
            time_valid <= 1'b1;
            sec_tick <= !time_valid || rd_sec != tm[SEC_LSB +: FIELD_W];
          end else read_time_req <= 1'b1;
        default:
          if (pend_set) begin
            state <= S_WRITE;
            wr_time <= mask_time(pend_time);
            pend_set <= 1'b0;
            write_time_req <= 1'b1;
          end else if (timer == TERM) begin
            state <= S_READ;
            read_time_req <= 1'b1;
          end else timer <= timer + 1'b1;
      endcase
      if (accept) begin
        pend_time <= set_time;
        pend_set <= 1'b1;
      end
    end
  end
endmodule
